// File: rtl/result_monitor_if.sv
// Port bundle for result_monitor. The stimulus side drives the control
// pulses and both result streams. The monitor side returns the comparison
// pulse, the XOR difference, the buffer occupancy and the status flags.
interface result_monitor_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             i_start;
  logic             i_flush;
  logic             i_exp_valid;
  logic [WIDTH-1:0] i_exp_data;
  logic             i_dut_valid;
  logic [WIDTH-1:0] i_dut_data;
  logic             o_mon_ready;
  logic [WIDTH-1:0] o_diff;
  logic [LW-1:0]    o_level;
  logic             o_overflow;
  logic             o_underflow;
  logic             o_busy;

  modport master (
    output i_start, i_flush, i_exp_valid, i_exp_data, i_dut_valid, i_dut_data,
    input  o_mon_ready, o_diff, o_level, o_overflow, o_underflow, o_busy
  );

  modport slave (
    input  i_start, i_flush, i_exp_valid, i_exp_data, i_dut_valid, i_dut_data,
    output o_mon_ready, o_diff, o_level, o_overflow, o_underflow, o_busy
  );
endinterface

// File: rtl/result_monitor.sv
// result_monitor: buffers golden-model results in a FIFO and compares each
// arriving DUT result against the oldest buffered entry. The comparison is
// reported one cycle later as a single-cycle o_mon_ready pulse, together with
// the bitwise XOR difference on o_diff. Sticky flags record dropped expected
// results (buffer full) and DUT results that found the buffer empty.
module result_monitor #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  result_monitor_if.slave  mon
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;
  logic             busy;

  // Expected-result storage; contents are don't-care whenever level says so,
  // so it carries no reset.
  logic [WIDTH-1:0] mem [DEPTH];

  // Comparison result stage: valid and data travel together.
  logic             vld_p1;
  logic [WIDTH-1:0] diff_p1;

  logic             active;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;
  logic             starve;

  // A flush cycle discards all traffic presented alongside it.
  assign active = (state == RUN) && !mon.i_flush;
  assign empty  = (level == '0);
  assign full   = (level == FULL_LEVEL);

  // A pop frees the head slot in the same cycle, so a full buffer can still
  // accept a push when a DUT result is consumed at the same time. An empty
  // buffer never forwards a same-cycle push to the DUT side.
  assign pop    = active && mon.i_dut_valid && !empty;
  assign push   = active && mon.i_exp_valid && (!full || pop);
  assign drop   = active && mon.i_exp_valid && full && !pop;
  assign starve = active && mon.i_dut_valid && empty;

  // Write accepted expected results at the tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= mon.i_exp_data;
    end
  end

  // Control FSM, FIFO bookkeeping, sticky flags and the registered comparison.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      vld_p1    <= 1'b0;
      diff_p1   <= '0;
    end else begin
      // --- stage p0 -> p1: compare head against the DUT result ---
      vld_p1 <= pop;
      if (pop) begin
        diff_p1 <= mon.i_dut_data ^ mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end

      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (push && !pop) begin
        level <= level + 1'b1;
      end else if (pop && !push) begin
        level <= level - 1'b1;
      end

      if (drop) begin
        overflow <= 1'b1;
      end
      if (starve) begin
        underflow <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (mon.i_start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (mon.i_flush) begin
            state <= FLUSH;
          end
        end
        FLUSH: begin
          state     <= IDLE;
          busy      <= 1'b0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          level     <= '0;
          overflow  <= 1'b0;
          underflow <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mon.o_mon_ready = vld_p1;
  assign mon.o_diff      = diff_p1;
  assign mon.o_level     = level;
  assign mon.o_overflow  = overflow;
  assign mon.o_underflow = underflow;
  assign mon.o_busy      = busy;

endmodule

// File: tb/tb_result_monitor.sv
// Testbench for result_monitor: directed scenarios followed by random
// traffic, checked against a queue-based reference model. Expected comparison
// pulses go into a scoreboard tagged with the cycle they are due in; a
// separate monitor process consumes them whenever the DUT raises o_mon_ready.
module tb_result_monitor;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    int          due;
    logic [31:0] diff;
  } pulse_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  result_monitor_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  result_monitor #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus.slave)
  );

  // Reference model state
  logic [31:0] m_fifo[$];
  pulse_t      sb[$];
  int          m_mode;      // 0 idle, 1 run, 2 flush
  logic        m_ovf;
  logic        m_unf;
  logic [31:0] m_diff;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest scoreboard entry in both value
  // and cycle; entries whose cycle passed without a pulse are reported.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      pulse_t p;
      p = sb.pop_front();
      check("missing_pulse_cycle", 32'(cyc), 32'(p.due));
    end
    if (bus.o_mon_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        pulse_t p;
        p = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(p.due));
        check("pulse_diff", bus.o_diff, p.diff);
      end
    end
  end

  // One clock of stimulus: update the model with the inputs, apply them
  // across a rising edge, then compare the status outputs with the model.
  task automatic step(input logic rst_i, input logic st, input logic fl,
                      input logic ev, input logic [31:0] ed,
                      input logic dv, input logic [31:0] dd);
    reset           = rst_i;
    bus.i_start     = st;
    bus.i_flush     = fl;
    bus.i_exp_valid = ev;
    bus.i_exp_data  = ed;
    bus.i_dut_valid = dv;
    bus.i_dut_data  = dd;

    if (rst_i) begin
      m_mode = 0;
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_diff = '0;
    end else if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (fl) begin
        m_mode = 2;
      end else begin
        if (dv) begin
          if (m_fifo.size() > 0) begin
            logic [31:0] head;
            pulse_t      p;
            head   = m_fifo.pop_front();
            m_diff = dd ^ head;
            p.due  = cyc + 1;
            p.diff = m_diff;
            sb.push_back(p);
          end else begin
            m_unf = 1'b1;
          end
        end
        if (ev) begin
          if (m_fifo.size() < DEPTH) m_fifo.push_back(ed);
          else m_ovf = 1'b1;
        end
      end
    end else begin
      m_mode = 0;
      m_fifo.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end

    @(posedge clk);
    #1;
    check("o_level", 32'(bus.o_level), 32'(m_fifo.size()));
    check("o_overflow", 32'(bus.o_overflow), 32'(m_ovf));
    check("o_underflow", 32'(bus.o_underflow), 32'(m_unf));
    check("o_busy", 32'(bus.o_busy), (m_mode != 0) ? 32'd1 : 32'd0);
    check("o_diff_hold", bus.o_diff, m_diff);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic push(input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b1, d, 1'b0, '0);
  endtask

  task automatic dutv(input logic [31:0] d);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1, d);
  endtask

  task automatic start();
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic flush();
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, '0);
    idle();
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    m_mode = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_diff = '0;
    reset  = 1'b1;
    bus.i_start = 1'b0; bus.i_flush = 1'b0;
    bus.i_exp_valid = 1'b0; bus.i_exp_data = '0;
    bus.i_dut_valid = 1'b0; bus.i_dut_data = '0;
    @(negedge clk);

    // Reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_mon_ready", 32'(bus.o_mon_ready), 32'd0);

    // Matching result two cycles after the push
    start();
    push(32'hA5A5A5A5);
    idle();
    dutv(32'hA5A5A5A5);
    idle();
    check("match_level_zero", 32'(bus.o_level), 32'd0);

    // Single-bit difference
    push(32'h0000000F);
    dutv(32'h0000000E);
    idle();
    check("lsb_diff_held", bus.o_diff, 32'h00000001);

    // Fill past capacity, then push and pop together while full
    for (int i = 0; i < DEPTH + 1; i++) push(32'h1000 + 32'(i));
    check("full_level", 32'(bus.o_level), 32'(DEPTH));
    check("full_overflow", 32'(bus.o_overflow), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'hBEEF, 1'b1, 32'h1000);
    check("full_pushpop_level", 32'(bus.o_level), 32'(DEPTH));

    // Drain to 5 entries, then flush together with a DUT result
    for (int i = 0; i < DEPTH - 5; i++) dutv(32'($urandom));
    check("level_five", 32'(bus.o_level), 32'd5);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 32'h1234);
    check("flush_busy", 32'(bus.o_busy), 32'd1);
    idle();
    check("flush_level", 32'(bus.o_level), 32'd0);
    check("flush_ovf", 32'(bus.o_overflow), 32'd0);
    dutv(32'h5555);
    idle();

    // Empty buffer: DUT and expected result in the same cycle
    start();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h77, 1'b1, 32'h77);
    check("empty_underflow", 32'(bus.o_underflow), 32'd1);
    check("empty_level", 32'(bus.o_level), 32'd1);
    idle();
    flush();

    // Reset wins over a same-cycle start with data buffered
    start();
    push(32'h1); push(32'h2); push(32'h3);
    step(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0, '0);
    check("reset_start_busy", 32'(bus.o_busy), 32'd0);
    check("reset_start_level", 32'(bus.o_level), 32'd0);
    check("reset_start_diff", bus.o_diff, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic r, s, f, e, d;
      r = ($urandom_range(0, 299) == 0);
      s = ($urandom_range(0, 9) == 0);
      f = ($urandom_range(0, 79) == 0);
      e = ($urandom_range(0, 99) < 55);
      d = ($urandom_range(0, 99) < 45);
      step(r, s, f, e, $urandom, d, ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 15)));
    end

    idle();
    idle();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_monitor.md
RESULT_MONITOR -- requirements
Module: result_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of the expected and DUT results (1..32).
REQ-002 SHALL have parameter DEPTH, default 16: expected-result buffer entries (power of 2, at least 2).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  single-cycle pulse; arms monitor from IDLE.
REQ-006 i_flush  input  1  single-cycle pulse; aborts run, discards buffered data.
REQ-007 i_exp_valid  input  1  golden-model result present this cycle.
REQ-008 i_exp_data  input  WIDTH  golden-model result.
REQ-009 i_dut_valid  input  1  DUT result present this cycle.
REQ-010 i_dut_data  input  WIDTH  DUT result.
REQ-011 o_mon_ready  output  1  one-cycle pulse: o_diff holds a fresh comparison; feeds scoreboard i_mon_ready.
REQ-012 o_diff  output  WIDTH  bitwise XOR of DUT and expected result; feeds scoreboard i_diff.
REQ-013 o_level  output  log2(DEPTH)+1  current buffer occupancy.
REQ-014 o_overflow  output  1  sticky: expected result dropped, buffer full.
REQ-015 o_underflow  output  1  sticky: DUT result arrived with buffer empty.
REQ-016 o_busy  output  1  high when state is not IDLE.

Function
REQ-017 SHALL implement states IDLE, RUN, FLUSH.
REQ-018 IDLE -> RUN on i_start; i_flush, i_exp_valid and i_dut_valid ignored in IDLE.
REQ-019 RUN -> FLUSH on i_flush; i_start ignored in RUN; push and compare activity in the i_flush cycle is discarded.
REQ-020 FLUSH lasts exactly one cycle, then IDLE; on that edge pointers clear, o_level=0, o_overflow=0, o_underflow=0.
REQ-021 In RUN, i_exp_valid SHALL write i_exp_data into the FIFO when o_level<DEPTH, or when o_level==DEPTH and a pop occurs in the same cycle.
REQ-022 In RUN, i_exp_valid with o_level==DEPTH and no pop SHALL drop the data and set o_overflow.
REQ-023 In RUN, i_dut_valid with o_level>0 SHALL pop the head entry, register o_diff <= i_dut_data ^ head, and pulse o_mon_ready on the next cycle; latency is 1 cycle.
REQ-024 In RUN, i_dut_valid with o_level==0 SHALL set o_underflow, produce no o_mon_ready pulse, and leave o_diff unchanged; a same-cycle i_exp_valid is written normally with no bypass.
REQ-025 Simultaneous push and pop SHALL leave o_level unchanged.
REQ-026 Pointers SHALL wrap modulo DEPTH; o_level SHALL count 0..DEPTH inclusive.
REQ-027 o_diff SHALL hold its last value while o_mon_ready is low.
REQ-028 o_mon_ready SHALL be high for at most one cycle per accepted DUT result; back-to-back pops give consecutive pulses.
REQ-029 Sticky flags SHALL clear only on reset or in FLUSH.

Reset
REQ-030 reset SHALL take priority over all inputs, including i_start and i_flush in the same cycle.
REQ-031 On reset: state=IDLE, o_mon_ready=0, o_diff=0, o_level=0, o_overflow=0, o_underflow=0, o_busy=0.
REQ-032 Reset mid-RUN SHALL discard buffered data; the FIFO storage array need not be cleared.

Verification
REQ-033 Reset, i_start, push 0xA5A5A5A5, then DUT 0xA5A5A5A5 two cycles later -> one o_mon_ready pulse one cycle after the DUT cycle, o_diff=0, o_level returns to 0.
REQ-034 Push 0x0000000F, then DUT 0x0000000E -> o_diff=0x00000001, single pulse.
REQ-035 DEPTH=16: push 17 values with no DUT -> o_level=16, o_overflow=1 from the 17th push onward; then push and DUT together -> write accepted, o_level stays 16.
REQ-036 Empty buffer: i_dut_valid and i_exp_valid in the same cycle -> o_underflow=1, no pulse, o_level=1.
REQ-037 In RUN with o_level=5 and o_overflow=1, pulse i_flush with i_dut_valid -> no pulse, o_busy high one more cycle, then IDLE with o_level=0, flags 0; i_dut_valid in IDLE has no effect.
REQ-038 Assert reset in the same cycle as i_start with o_level=3 -> IDLE, all outputs at reset values, o_busy=0.
